// File: rtl/mxint8_block_quantizer_pkg.sv
// Shared definitions for the MXINT8 block quantizer: float32 fields, E8M0 constants, FSM states.
// Subnormal handling is selected with the MXINT8_SUBNORMAL_EN macro.
package mxint8_block_quantizer_pkg;

  localparam int F32_SIGN_BIT = 31;
  localparam int F32_EXP_MSB  = 30;
  localparam int F32_EXP_LSB  = 23;
  localparam int F32_MANT_MSB = 22;

  localparam logic [7:0] E8M0_NAN           = 8'hFF;
  localparam int         DEFAULT_BLOCK_SIZE = 32;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_QUANT   = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // Exponent used for scale selection and alignment; zeros map to 0 so they never raise the max.
  function automatic logic [7:0] eff_exp(input logic [31:0] f);
`ifdef MXINT8_SUBNORMAL_EN
    if (f[F32_EXP_MSB:F32_EXP_LSB] == 8'd0) begin
      eff_exp = (f[F32_MANT_MSB:0] != 23'd0) ? 8'd1 : 8'd0;
    end else begin
      eff_exp = f[F32_EXP_MSB:F32_EXP_LSB];
    end
`else
    eff_exp = f[F32_EXP_MSB:F32_EXP_LSB];
`endif
  endfunction

  // 24-bit significand with hidden bit; exp-0 inputs are subnormal or flushed depending on build.
  function automatic logic [23:0] eff_sig(input logic [31:0] f);
    logic hidden;
    hidden = (f[F32_EXP_MSB:F32_EXP_LSB] != 8'd0);
`ifdef MXINT8_SUBNORMAL_EN
    eff_sig = {hidden, f[F32_MANT_MSB:0]};
`else
    eff_sig = hidden ? {1'b1, f[F32_MANT_MSB:0]} : 24'd0;
`endif
  endfunction

endpackage

// File: rtl/mxint8_element_quantize.sv
// Combinational float32 -> signed MXINT element against a shared exponent (shift, RNE, clamp, sign).
// Subnormal treatment follows MXINT8_SUBNORMAL_EN through the package helpers.
module mxint8_element_quantize
  import mxint8_block_quantizer_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic [31:0]              float32,
  input  logic [7:0]               max_exp,
  output logic [ELEMENT_WIDTH-1:0] element
);

  localparam int MW = ELEMENT_WIDTH - 1;

  logic [7:0]    exp_s;
  logic [7:0]    d_s;
  logic [23:0]   sig_s;
  logic [47:0]   shifted_s;
  logic [MW-1:0] mag_s;
  logic          guard_s;
  logic          sticky_s;
  logic          round_up_s;
  logic [MW:0]   sum_s;
  logic [MW-1:0] sat_s;

  // Align to the block exponent, round to nearest even, clamp symmetrically, apply sign
  always_comb begin
    exp_s      = eff_exp(float32);
    sig_s      = eff_sig(float32);
    d_s        = max_exp - exp_s;
    shifted_s  = {sig_s, 24'd0} >> d_s;
    mag_s      = shifted_s[47 -: MW];
    guard_s    = shifted_s[47 - MW];
    sticky_s   = |shifted_s[46 - MW:0];
    round_up_s = guard_s & (sticky_s | mag_s[0]);
    sum_s      = {1'b0, mag_s} + {{MW{1'b0}}, round_up_s};
    sat_s      = sum_s[MW] ? {MW{1'b1}} : sum_s[MW-1:0];
    element    = float32[F32_SIGN_BIT] ? (~{1'b0, sat_s} + {{MW{1'b0}}, 1'b1})
                                       : {1'b0, sat_s};
  end

endmodule

// File: rtl/mxint8_block_quantizer.sv
// Streaming float32 -> MXINT8 block quantizer: collect BLOCK_SIZE values, quantize one per cycle,
// hold the block until accepted. MXINT8_SUBNORMAL_EN enables subnormal inputs.
module mxint8_block_quantizer
  import mxint8_block_quantizer_pkg::*;
#(
  parameter int BLOCK_SIZE    = DEFAULT_BLOCK_SIZE,
  parameter int ELEMENT_WIDTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  input  logic [31:0]                         i_float32,
  output logic                                o_ready,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [7:0]                          o_scale,
  output logic [BLOCK_SIZE*ELEMENT_WIDTH-1:0] o_mxint8_elements
);

  localparam int             CW       = $clog2(BLOCK_SIZE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t                   state_r;
  logic [CW-1:0]            cnt_r;
  logic [7:0]               max_exp_r;
  logic                     nan_seen_r;
  logic [31:0]              buf_r [BLOCK_SIZE];
  logic [ELEMENT_WIDTH-1:0] q_elem_s;
  logic [7:0]               in_exp_s;
  logic                     xfer_s;
  logic                     last_s;

  assign o_ready  = (state_r == ST_COLLECT) && !i_rst;
  assign xfer_s   = i_valid && o_ready;
  assign last_s   = (cnt_r == CNT_LAST);
  assign in_exp_s = eff_exp(i_float32);

  mxint8_element_quantize #(
    .ELEMENT_WIDTH(ELEMENT_WIDTH)
  ) u_elem (
    .float32 (buf_r[cnt_r]),
    .max_exp (max_exp_r),
    .element (q_elem_s)
  );

  // Sample buffer; contents are only meaningful for the block in flight
  always_ff @(posedge i_clk) begin
    if (xfer_s) begin
      buf_r[cnt_r] <= i_float32;
    end
  end

  // Block FSM: collect inputs, quantize one slot per cycle, hold the result until taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r           <= ST_COLLECT;
      cnt_r             <= '0;
      max_exp_r         <= 8'd0;
      nan_seen_r        <= 1'b0;
      o_valid           <= 1'b0;
      o_scale           <= 8'd0;
      o_mxint8_elements <= '0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (xfer_s) begin
            max_exp_r  <= (in_exp_s > max_exp_r) ? in_exp_s : max_exp_r;
            nan_seen_r <= nan_seen_r | (i_float32[F32_EXP_MSB:F32_EXP_LSB] == 8'hFF);
            cnt_r      <= last_s ? '0 : cnt_r + CNT_ONE;
            state_r    <= last_s ? ST_QUANT : ST_COLLECT;
          end
        end
        ST_QUANT: begin
          // A NaN/Inf anywhere in the block zeroes every element
          o_mxint8_elements[cnt_r*ELEMENT_WIDTH +: ELEMENT_WIDTH] <=
            nan_seen_r ? {ELEMENT_WIDTH{1'b0}} : q_elem_s;
          cnt_r <= last_s ? '0 : cnt_r + CNT_ONE;
          if (last_s) begin
            o_scale <= nan_seen_r ? E8M0_NAN : max_exp_r;
            o_valid <= 1'b1;
            state_r <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (i_ready) begin
            o_valid    <= 1'b0;
            max_exp_r  <= 8'd0;
            nan_seen_r <= 1'b0;
            cnt_r      <= '0;
            state_r    <= ST_COLLECT;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
          cnt_r   <= '0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mxint8_block_quantizer.sv
// Directed self-checking bench for mxint8_block_quantizer (expectations follow MXINT8_SUBNORMAL_EN).
module tb_mxint8_block_quantizer;

  localparam int BS = 32;
  localparam int EW = 8;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic [31:0]       i_float32;
  logic              o_ready;
  logic              o_valid;
  logic              i_ready;
  logic [7:0]        o_scale;
  logic [BS*EW-1:0]  o_mxint8_elements;

  logic [31:0] blk   [BS];
  logic [7:0]  exp_e [BS];
  int cyc = 0;
  int last_xfer = 0;
  int tests_run = 0;
  int tests_failed = 0;

  mxint8_block_quantizer #(.BLOCK_SIZE(BS), .ELEMENT_WIDTH(EW)) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_valid           (i_valid),
    .i_float32         (i_float32),
    .o_ready           (o_ready),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_scale           (o_scale),
    .o_mxint8_elements (o_mxint8_elements)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fill(input logic [31:0] v, input logic [7:0] e);
    for (int i = 0; i < BS; i++) begin
      blk[i] = v;
      exp_e[i] = e;
    end
  endtask

  function automatic logic [BS*EW-1:0] pack_exp();
    logic [BS*EW-1:0] v;
    for (int i = 0; i < BS; i++) v[i*EW +: EW] = exp_e[i];
    return v;
  endfunction

  task automatic send_block(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      @(negedge clk);
      while (!o_ready && g < 200) begin
        @(negedge clk);
        g++;
      end
      i_valid = 1'b1;
      i_float32 = blk[i];
    end
    @(negedge clk);
    i_valid = 1'b0;
    last_xfer = cyc;
  endtask

  task automatic wait_valid(output bit to);
    int g;
    g = 0;
    while (!o_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    to = !o_valid;
  endtask

  task automatic accept_block();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_float32 = 32'd0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
    tests_run++;
    if (o_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    tests_run++;
    if (o_scale !== 8'd0) begin tests_failed++; $display("FAIL reset_scale: got %h expected 00", o_scale); end
    tests_run++;
    if (o_mxint8_elements !== '0) begin tests_failed++; $display("FAIL reset_elements: got %h expected 0", o_mxint8_elements); end
    i_rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_uniform();
    bit to;
    int lat;
    fill(32'h3F800000, 8'h40);
    send_block(BS);
    wait_valid(to);
    lat = cyc - last_xfer;
    tests_run++;
    if (to || lat != 32) begin tests_failed++; $display("FAIL uniform_latency: got %0d timeout=%0b expected 32", lat, to); end
    tests_run++;
    if (o_scale !== 8'd127) begin tests_failed++; $display("FAIL uniform_scale: got %h expected 7f", o_scale); end
    for (int i = 0; i < BS; i++) begin
      tests_run++;
      if (o_mxint8_elements[i*EW +: EW] !== exp_e[i]) begin
        tests_failed++; $display("FAIL uniform_elem%0d: got %h expected %h", i, o_mxint8_elements[i*EW +: EW], exp_e[i]);
      end
    end
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL uniform_overlap: o_ready %b expected 0", o_ready); end
    accept_block();
    tests_run++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      tests_failed++; $display("FAIL uniform_after_accept: ready=%b valid=%b expected 1/0", o_ready, o_valid);
    end
  endtask

  task automatic test_mixed();
    bit to;
    fill(32'h3F800000, 8'h20);
    blk[0]  = 32'h40000000; exp_e[0]  = 8'h40;
    blk[5]  = 32'hBFC00000; exp_e[5]  = 8'hD0;
    blk[9]  = 32'h00000000; exp_e[9]  = 8'h00;
    blk[10] = 32'h80000000; exp_e[10] = 8'h00;
    blk[11] = 32'h3A800000; exp_e[11] = 8'h00;
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'd128) begin tests_failed++; $display("FAIL mixed_scale: got %h timeout=%0b expected 80", o_scale, to); end
    for (int i = 0; i < BS; i++) begin
      tests_run++;
      if (o_mxint8_elements[i*EW +: EW] !== exp_e[i]) begin
        tests_failed++; $display("FAIL mixed_elem%0d: got %h expected %h", i, o_mxint8_elements[i*EW +: EW], exp_e[i]);
      end
    end
    accept_block();
  endtask

  task automatic test_saturation_rne();
    bit to;
    fill(32'h3FFFFFFF, 8'h7F);
    blk[3] = 32'hBFFFFFFF; exp_e[3] = 8'h81;
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'd127) begin tests_failed++; $display("FAIL sat_scale: got %h timeout=%0b expected 7f", o_scale, to); end
    tests_run++;
    if (o_mxint8_elements !== pack_exp()) begin tests_failed++; $display("FAIL sat_elements: got %h expected %h", o_mxint8_elements, pack_exp()); end
    accept_block();
    fill(32'h3F800000, 8'h20);
    blk[0] = 32'h40000000; exp_e[0] = 8'h40;
    blk[1] = 32'h3F820000; exp_e[1] = 8'h20;
    blk[2] = 32'h3F860000; exp_e[2] = 8'h22;
    blk[3] = 32'h3F830000; exp_e[3] = 8'h21;
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'd128) begin tests_failed++; $display("FAIL rne_scale: got %h timeout=%0b expected 80", o_scale, to); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (o_mxint8_elements[i*EW +: EW] !== exp_e[i]) begin
        tests_failed++; $display("FAIL rne_elem%0d: got %h expected %h", i, o_mxint8_elements[i*EW +: EW], exp_e[i]);
      end
    end
    tests_run++;
    if (o_mxint8_elements !== pack_exp()) begin tests_failed++; $display("FAIL rne_elements: got %h expected %h", o_mxint8_elements, pack_exp()); end
    accept_block();
  endtask

  task automatic test_nan();
    bit to;
    fill(32'h3F800000, 8'h00);
    blk[7] = 32'h7FC00000;
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'hFF) begin tests_failed++; $display("FAIL nan_scale: got %h timeout=%0b expected ff", o_scale, to); end
    tests_run++;
    if (o_mxint8_elements !== '0) begin tests_failed++; $display("FAIL nan_elements: got %h expected 0", o_mxint8_elements); end
    accept_block();
  endtask

  task automatic test_backpressure();
    bit to;
    fill(32'h3F800000, 8'h40);
    send_block(BS);
    wait_valid(to);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_scale !== 8'd127 || o_mxint8_elements !== pack_exp()) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b scale=%h expected 1/0/7f with block held", k, o_valid, o_ready, o_scale);
      end
    end
    accept_block();
    fill(32'h3F800000, 8'h20);
    blk[31] = 32'h40000000; exp_e[31] = 8'h40;
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'd128 || o_mxint8_elements !== pack_exp()) begin
      tests_failed++; $display("FAIL after_hold_block: scale=%h timeout=%0b expected 80 with packed block", o_scale, to);
    end
    accept_block();
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    fill(32'h40800000, 8'h40);
    send_block(10);
    i_rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (o_ready !== 1'b0) begin tests_failed++; $display("FAIL midreset_ready: got %b expected 0", o_ready); end
    @(negedge clk);
    i_rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin tests_failed++; $display("FAIL midreset_valid: got 1 expected 0"); end
    fill(32'h3F800000, 8'h40);
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== 8'd127 || o_mxint8_elements !== pack_exp()) begin
      tests_failed++; $display("FAIL midreset_fresh_block: scale=%h timeout=%0b expected 7f with all 40", o_scale, to);
    end
    accept_block();
  endtask

  task automatic test_subnormal();
    bit to;
    logic [7:0] exp_scale;
`ifdef MXINT8_SUBNORMAL_EN
    fill(32'h00400000, 8'h20);
    exp_scale = 8'd1;
`else
    fill(32'h00400000, 8'h00);
    exp_scale = 8'd0;
`endif
    send_block(BS);
    wait_valid(to);
    tests_run++;
    if (to || o_scale !== exp_scale) begin tests_failed++; $display("FAIL subnormal_scale: got %h timeout=%0b expected %h", o_scale, to, exp_scale); end
    tests_run++;
    if (o_mxint8_elements !== pack_exp()) begin tests_failed++; $display("FAIL subnormal_elements: got %h expected %h", o_mxint8_elements, pack_exp()); end
    accept_block();
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_mixed();
    test_saturation_rne();
    test_nan();
    test_backpressure();
    test_reset_mid();
    test_subnormal();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
